// File: rtl/pair_collision_scanner.sv
// pair_collision_scanner: time-multiplexed all-pairs collision resolver.
// One 3-stage distance pipeline walks every unordered sprite pair once per
// start; colliding pairs swap velocities in a working copy in scan order.
// Optional feature macro: PAIR_COUNT_EN adds the collision_count port/counter.
module pair_collision_scanner #(
  parameter int              SPRITES    = 9,
  parameter int              DIMENSIONS = 2,
  parameter int              WIDTH      = 32,
  parameter longint unsigned RADIUS_SQ  = 64'd3844
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations,
  input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] velos,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] new_velos,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         collision
`ifdef PAIR_COUNT_EN
  ,
  output logic [$clog2(SPRITES*(SPRITES-1)/2+1)-1:0]    collision_count
`endif
);

  localparam int P      = SPRITES * (SPRITES - 1) / 2;
  localparam int IDX_W  = $clog2(SPRITES);
  localparam int SQ_W   = 2 * WIDTH;
  localparam int SUM_W  = 2 * WIDTH + $clog2(DIMENSIONS);
  localparam int CMP_W  = (SUM_W > 64) ? SUM_W : 64;

  typedef logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] sprite_arr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  // Magnitude of the difference, never wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Full-precision square of one axis magnitude.
  function automatic logic [SQ_W-1:0] square(input logic [WIDTH-1:0] v);
    return SQ_W'(v) * SQ_W'(v);
  endfunction

`ifdef PAIR_COUNT_EN
  localparam int CNT_W = $clog2(P + 1);

  // Hit counter increment that sticks at P.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(P)) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
`endif

  state_t                               state;
  logic [IDX_W-1:0]                     idx_i, idx_j;
  logic                                 last_pair;
  logic                                 drain_q;
  logic                                 hit_q;
  logic                                 hit_next;
  logic                                 commit;

  sprite_arr_t                          loc_q;
  sprite_arr_t                          vel_q;
  sprite_arr_t                          vel_next;

  logic [DIMENSIONS-1:0][WIDTH-1:0]     diff_p0;
  logic [IDX_W-1:0]                     pi_p0, pj_p0;
  logic                                 vld_p0;

  logic [SUM_W-1:0]                     sq_sum;
  logic [SUM_W-1:0]                     d2_p1;
  logic [IDX_W-1:0]                     pi_p1, pj_p1;
  logic                                 vld_p1;

  assign last_pair = (idx_i == IDX_W'(SPRITES - 2)) && (idx_j == IDX_W'(SPRITES - 1));

  // Sum the per-axis squares at full width.
  always_comb begin
    sq_sum = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      sq_sum = sq_sum + SUM_W'(square(diff_p0[d]));
    end
  end

  assign commit   = vld_p1 && (CMP_W'(d2_p1) <= CMP_W'(RADIUS_SQ));
  assign hit_next = hit_q | commit;
`ifdef PAIR_COUNT_EN
  assign cnt_next = commit ? sat_inc(cnt_q) : cnt_q;
`endif

  // Working velocities after this cycle's commit (swap whole sprite vectors).
  always_comb begin
    vel_next = vel_q;
    if (commit) begin
      vel_next[pi_p1] = vel_q[pj_p1];
      vel_next[pj_p1] = vel_q[pi_p1];
    end
  end

  // Control: FSM, pair issue, valids, hit tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_i     <= '0;
      idx_j     <= '0;
      drain_q   <= 1'b0;
      hit_q     <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      new_velos <= '0;
`ifdef PAIR_COUNT_EN
      cnt_q           <= '0;
      collision_count <= '0;
`endif
    end else begin
      done   <= 1'b0;
      vld_p0 <= (state == ST_SCAN);
      vld_p1 <= vld_p0;
      hit_q  <= hit_next;
`ifdef PAIR_COUNT_EN
      cnt_q  <= cnt_next;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SCAN;
            busy  <= 1'b1;
            idx_i <= '0;
            idx_j <= IDX_W'(1);
            hit_q <= 1'b0;
`ifdef PAIR_COUNT_EN
            cnt_q <= '0;
`endif
          end
        end
        ST_SCAN: begin
          if (last_pair) begin
            state   <= ST_DRAIN;
            drain_q <= 1'b0;
          end else if (idx_j == IDX_W'(SPRITES - 1)) begin
            idx_i <= idx_i + IDX_W'(1);
            idx_j <= idx_i + IDX_W'(2);
          end else begin
            idx_j <= idx_j + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          // The last pair commits in the second drain cycle; publish its result.
          if (drain_q) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            new_velos <= vel_next;
            collision <= hit_next;
`ifdef PAIR_COUNT_EN
            collision_count <= cnt_next;
`endif
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: snapshot, S1 (axis magnitudes) -> p0, S2 (squared sum) -> p1, S3 commit.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start) begin
      loc_q <= locations;
      vel_q <= velos;
    end else begin
      vel_q <= vel_next;
    end
    for (int d = 0; d < DIMENSIONS; d++) begin
      diff_p0[d] <= abs_diff(loc_q[idx_i][d], loc_q[idx_j][d]);
    end
    pi_p0 <= idx_i;
    pj_p0 <= idx_j;
    d2_p1 <= sq_sum;
    pi_p1 <= pi_p0;
    pj_p1 <= pj_p0;
  end

endmodule

// File: tb/tb_pair_collision_scanner.sv
// Self-checking bench for pair_collision_scanner (3 sprites, 2 axes, 16 bits).
// Reference model resolves pairs with plain nested loops and integer distances.
module tb_pair_collision_scanner;

  localparam int              S  = 3;
  localparam int              D  = 2;
  localparam int              W  = 16;
  localparam longint unsigned R  = 64'd3844;
  localparam int              P  = S * (S - 1) / 2;
  localparam int              CW = $clog2(P + 1);

  typedef logic [S-1:0][D-1:0][W-1:0] arr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  arr_t locations;
  arr_t velos;
  arr_t new_velos;
  logic busy;
  logic done;
  logic collision;
`ifdef PAIR_COUNT_EN
  logic [CW-1:0] collision_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pair_collision_scanner #(
    .SPRITES(S), .DIMENSIONS(D), .WIDTH(W), .RADIUS_SQ(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .locations(locations),
    .velos(velos),
    .new_velos(new_velos),
    .busy(busy),
    .done(done),
    .collision(collision)
`ifdef PAIR_COUNT_EN
    ,
    .collision_count(collision_count)
`endif
  );

  function automatic arr_t mk3(input int x0, input int y0, input int x1,
                               input int y1, input int x2, input int y2);
    arr_t a;
    a[0][0] = W'(x0); a[0][1] = W'(y0);
    a[1][0] = W'(x1); a[1][1] = W'(y1);
    a[2][0] = W'(x2); a[2][1] = W'(y2);
    return a;
  endfunction

  function automatic arr_t rand_arr(input int hi);
    arr_t a;
    for (int s = 0; s < S; s++)
      for (int d = 0; d < D; d++)
        a[s][d] = W'($urandom_range(0, hi));
    return a;
  endfunction

  // Reference: visit pairs (i<j) in lexicographic order, swap on d^2 <= R.
  task automatic model(input arr_t l, input arr_t v, output arr_t vo, output int hits);
    logic [D-1:0][W-1:0] tmp;
    longint d2, a, b;
    vo = v;
    hits = 0;
    for (int i = 0; i < S; i++) begin
      for (int j = i + 1; j < S; j++) begin
        d2 = 0;
        for (int d = 0; d < D; d++) begin
          a = longint'(l[i][d]);
          b = longint'(l[j][d]);
          d2 += (a - b) * (a - b);
        end
        if (d2 <= longint'(R)) begin
          tmp = vo[i]; vo[i] = vo[j]; vo[j] = tmp;
          hits++;
        end
      end
    end
  endtask

  // Launch one scan from IDLE and record what the DUT publishes; inputs are
  // scrambled every cycle afterwards so only the snapshot may matter.
  task automatic run_scan(input arr_t l, input arr_t v, output int dcyc,
                          output int pulses, output arr_t nv, output logic col,
                          output logic [CW-1:0] cnt, output logic busy_ok);
    locations = l; velos = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = -1; pulses = 0; busy_ok = 1'b1; nv = '0; col = 1'b0; cnt = '0;
    for (int k = 1; k <= 12; k++) begin
      if (done === 1'b1) begin
        pulses++;
        if (dcyc < 0) begin
          dcyc = k; nv = new_velos; col = collision;
`ifdef PAIR_COUNT_EN
          cnt = collision_count;
`endif
        end
      end
      if (busy !== (k <= P + 2)) busy_ok = 1'b0;
      locations = rand_arr(65535);
      velos = rand_arr(65535);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    locations = rand_arr(65535); velos = rand_arr(65535);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got=%b exp=0", collision); end
    checks++; if (new_velos !== '0) begin errors++; $display("FAIL reset_new_velos got=%h exp=0", new_velos); end
`ifdef PAIR_COUNT_EN
    checks++; if (collision_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", collision_count); end
`endif
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got=%b exp=0", busy); end
  endtask

  task automatic test_no_hit();
    arr_t l, v, nv; int dc, pu; logic col, bok; logic [CW-1:0] cnt;
    l = mk3(0, 0, 100, 0, 0, 100);
    v = rand_arr(65535);
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (dc != 6) begin errors++; $display("FAIL nohit_done_cycle got=%0d exp=6", dc); end
    checks++; if (pu != 1) begin errors++; $display("FAIL nohit_done_pulses got=%0d exp=1", pu); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL nohit_busy_window got=%b exp=1", bok); end
    checks++; if (nv !== v) begin errors++; $display("FAIL nohit_velos got=%h exp=%h", nv, v); end
    checks++; if (col !== 1'b0) begin errors++; $display("FAIL nohit_collision got=%b exp=0", col); end
`ifdef PAIR_COUNT_EN
    checks++; if (cnt !== CW'(0)) begin errors++; $display("FAIL nohit_count got=%0d exp=0", cnt); end
`endif
    checks++; if (new_velos !== v) begin errors++; $display("FAIL nohit_hold got=%h exp=%h", new_velos, v); end
  endtask

  task automatic test_threshold();
    arr_t l, v, nv, e; int dc, pu; logic col, bok; logic [CW-1:0] cnt;
    v = rand_arr(65535);
    e = v; e[0] = v[1]; e[1] = v[0];
    l = mk3(0, 0, 62, 0, 1000, 1000);
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (nv !== e) begin errors++; $display("FAIL thresh62_velos got=%h exp=%h", nv, e); end
    checks++; if (col !== 1'b1) begin errors++; $display("FAIL thresh62_collision got=%b exp=1", col); end
`ifdef PAIR_COUNT_EN
    checks++; if (cnt !== CW'(1)) begin errors++; $display("FAIL thresh62_count got=%0d exp=1", cnt); end
`endif
    l = mk3(0, 0, 63, 0, 1000, 1000);
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (nv !== v) begin errors++; $display("FAIL thresh63_velos got=%h exp=%h", nv, v); end
    checks++; if (col !== 1'b0) begin errors++; $display("FAIL thresh63_collision got=%b exp=0", col); end
  endtask

  task automatic test_sequential();
    arr_t l, v, nv, e; int dc, pu; logic col, bok; logic [CW-1:0] cnt;
    l = mk3(10, 10, 10, 10, 10, 10);
    v = rand_arr(65535);
    e[0] = v[2]; e[1] = v[1]; e[2] = v[0];
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (nv !== e) begin errors++; $display("FAIL seq_velos got=%h exp=%h", nv, e); end
    checks++; if (col !== 1'b1) begin errors++; $display("FAIL seq_collision got=%b exp=1", col); end
`ifdef PAIR_COUNT_EN
    checks++; if (cnt !== CW'(3)) begin errors++; $display("FAIL seq_count got=%0d exp=3", cnt); end
`endif
  endtask

  task automatic test_no_wrap();
    arr_t l, v, nv; int dc, pu; logic col, bok; logic [CW-1:0] cnt;
    l = mk3(0, 0, 65535, 0, 30000, 30000);
    v = rand_arr(65535);
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (col !== 1'b0) begin errors++; $display("FAIL nowrap_collision got=%b exp=0", col); end
    checks++; if (nv !== v) begin errors++; $display("FAIL nowrap_velos got=%h exp=%h", nv, v); end
  endtask

  task automatic test_random();
    arr_t l, v, nv, e; int dc, pu, h; logic col, bok; logic [CW-1:0] cnt;
    for (int t = 0; t < 12; t++) begin
      l = rand_arr(110);
      v = rand_arr(65535);
      model(l, v, e, h);
      run_scan(l, v, dc, pu, nv, col, cnt, bok);
      checks++; if (nv !== e) begin errors++; $display("FAIL rand%0d_velos got=%h exp=%h", t, nv, e); end
      checks++; if (col !== (h > 0)) begin errors++; $display("FAIL rand%0d_collision got=%b exp=%b", t, col, (h > 0)); end
`ifdef PAIR_COUNT_EN
      checks++; if (cnt !== CW'(h)) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, cnt, h); end
`endif
      checks++; if (dc != P + 3 || pu != 1) begin errors++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/1", t, dc, pu, P + 3); end
    end
  endtask

  task automatic test_handshake();
    arr_t l1, v1, l2, v2, e1, e2, nv6, nv13; int h;
    logic [15:0] dmask;
    logic [15:0] emask;
    l1 = rand_arr(110); v1 = rand_arr(65535);
    l2 = rand_arr(110); v2 = rand_arr(65535);
    model(l1, v1, e1, h);
    model(l2, v2, e2, h);
    dmask = '0; nv6 = '0; nv13 = '0;
    emask = '0; emask[6] = 1'b1; emask[13] = 1'b1;
    locations = l1; velos = v1; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 15; k++) begin
      if (done === 1'b1) dmask[k] = 1'b1;
      if (k == 6) nv6 = new_velos;
      if (k == 13) nv13 = new_velos;
      start = (k == 2) || (k == 7);
      if (k == 2) begin locations = l2; velos = v2; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (dmask !== emask) begin errors++; $display("FAIL handshake_done_cycles got=%b exp=%b", dmask, emask); end
    checks++; if (nv6 !== e1) begin errors++; $display("FAIL handshake_first_velos got=%h exp=%h", nv6, e1); end
    checks++; if (nv13 !== e2) begin errors++; $display("FAIL handshake_second_velos got=%h exp=%h", nv13, e2); end
  endtask

  task automatic test_reset_mid();
    arr_t l, v, nv, e; int dc, pu, h; logic col, bok, no_done; logic [CW-1:0] cnt;
    locations = mk3(10, 10, 10, 10, 10, 10); velos = rand_arr(65535); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (new_velos !== '0) begin errors++; $display("FAIL midrst_new_velos got=%h exp=0", new_velos); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL midrst_collision got=%b exp=0", collision); end
`ifdef PAIR_COUNT_EN
    checks++; if (collision_count !== '0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", collision_count); end
`endif
    no_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (done !== 1'b0) no_done = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (no_done !== 1'b1) begin errors++; $display("FAIL midrst_no_done got=%b exp=1", no_done); end
    l = rand_arr(110); v = rand_arr(65535);
    model(l, v, e, h);
    run_scan(l, v, dc, pu, nv, col, cnt, bok);
    checks++; if (nv !== e) begin errors++; $display("FAIL midrst_rescan_velos got=%h exp=%h", nv, e); end
    checks++; if (dc != P + 3) begin errors++; $display("FAIL midrst_rescan_cycle got=%0d exp=%0d", dc, P + 3); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; locations = '0; velos = '0;
    test_reset();
    test_no_hit();
    test_threshold();
    test_sequential();
    test_no_wrap();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_collision_scanner.md
# pair_collision_scanner

Time-multiplexed successor to the all-pairs collision handler. A single pipelined distance unit scans every unordered sprite pair once per `start`, instead of instantiating one detector per pair. Colliding pairs exchange velocities in a working copy, in scan order. The result is published to the motion-update stage as `new_velos`. The block is parametrised in sprite count, dimension count, coordinate width and collision radius.

## Interface
Parameters:
- `SPRITES`, 9: number of sprites; must be ≥ 2. `P = SPRITES*(SPRITES-1)/2` pairs.
- `DIMENSIONS`, 2: coordinate axes per sprite.
- `WIDTH`, 32: bits per coordinate and per velocity component.
- `RADIUS_SQ`, 3844: collision threshold on squared distance. A pair collides iff d² ≤ `RADIUS_SQ`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a scan; honoured only in IDLE.
- `locations` in `[SPRITES][DIMENSIONS][WIDTH]`: unsigned positions, sampled at `start`.
- `velos` in `[SPRITES][DIMENSIONS][WIDTH]`: velocities, sampled at `start`.
- `new_velos` out `[SPRITES][DIMENSIONS][WIDTH]`: resolved velocities; registered.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when `new_velos` is updated.
- `collision` out 1: at least one pair hit in the last completed scan.
- `collision_count` out `$clog2(P+1)`: hits in the last completed scan. Present only with `PAIR_COUNT_EN`.

## Operation
- FSM states: IDLE → SCAN → DRAIN → DONE → IDLE.
- **IDLE, `start`=1:** snapshot `locations` into `loc_q` and `velos` into `vel_q`. Clear the pair index and hit flag/count. Go to SCAN.
- **SCAN:** issue one pair per cycle in lexicographic order (0,1),(0,2)…(0,S-1),(1,2)…(S-2,S-1).
  - After the last pair is issued, go to DRAIN.
- **Pipeline**, one pair in flight per stage:
  - **S1:** per axis, `|a−b|` as an unsigned WIDTH-bit magnitude. No modular wrap: 0 vs 2^WIDTH−1 yields 2^WIDTH−1.
  - **S2:** square each axis to 2·WIDTH bits, then sum to `2·WIDTH+$clog2(DIMENSIONS)` bits with full precision and no truncation.
  - **S3 (commit):** if d² ≤ `RADIUS_SQ`, swap `vel_q[i]` and `vel_q[j]` (all axes), set the hit flag and increment the count.
- Commits apply sequentially to `vel_q`, so later pairs see earlier swaps. Distances come only from `loc_q`, so there is no pipeline hazard.
- **DRAIN:** wait 2 cycles until the last pair commits.
- **DONE:** `new_velos <= vel_q`, `collision <= hit flag`, `collision_count <= count`, `done`=1. Next state is IDLE.
- `start` outside IDLE is ignored and not queued. Inputs may change freely during a scan.

## Timing
- Edge 0 accepts `start`.
- Pairs are issued in cycles 1..P. Commits occur in cycles 3..P+2.
- `busy`=1 in cycles 1..P+2.
- `done`=1 and `new_velos` are valid in cycle P+3, with `busy`=0.
- The earliest next `start` is accepted in cycle P+4.
- Total latency from `start` to `done` is P+3 cycles.
- Outputs hold between scans.
- **Reset values:** `new_velos`=0, `busy`=0, `done`=0, `collision`=0, `collision_count`=0, FSM=IDLE.
- `rst` takes priority over `start` in the same cycle.
- `rst` mid-scan aborts the scan. No `done` is produced and outputs take their reset values.

## Configuration
- Macro: `PAIR_COUNT_EN`.
- **Defined:** the `collision_count` port and counter exist and update in DONE. The counter saturates at P, which is unreachable but sets the width.
- **Undefined:** no counter logic and no `collision_count` port. All other behaviour is identical.

## Test plan
Common setup: `SPRITES`=3, `DIMENSIONS`=2, `WIDTH`=16, `RADIUS_SQ`=3844, giving P=3 and `done` at cycle 6.
- **No hit:** locations (0,0),(100,0),(0,100); velos A,B,C → `done` only in cycle 6, `new_velos`=A,B,C, `collision`=0, count=0.
- **Threshold edge:**
  - Sprite 0 at (0,0), sprite 1 at (62,0) (d²=3844), sprite 2 far → v0/v1 swapped, count=1.
  - Repeat with sprite 1 at (63,0) (d²=3969) → no swap.
- **Sequential swaps:** all three at (10,10); velos A,B,C → after (0,1) B,A,C; after (0,2) C,A,B; after (1,2) C,B,A. Final `new_velos`=C,B,A, count=3, `collision`=1.
- **No wrap:** sprite 0 at (0,0), sprite 1 at (65535,0) → no collision; checks full-width d² with no overflow.
- **Handshake:** pulse `start` in cycle 0 and again in cycle 2 → the second is ignored and exactly one `done` occurs, in cycle 6. A `start` in cycle 7 (IDLE) is accepted, with its `done` in cycle 13.
- **Reset mid-scan:** `rst` in cycle 3 → `busy`=0 and all outputs 0 next cycle, with no `done`. A subsequent `start` completes normally with correct results.
